// File: rtl/readout_rr_scheduler.sv
// Per-event readout sequencer: header token, then round-robin single reads across N_MEM item memories.
// Define READOUT_WINDOW_EN to cap each event at WINDOW arbitration cycles and report truncation.
module readout_rr_scheduler #(
  parameter int N_MEM    = 20,
  parameter int MEM_SIZE = 6,
  parameter int RD_LAT   = 2,
  parameter int WINDOW   = 100
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [2:0]                bx,
  input  logic [N_MEM*MEM_SIZE-1:0] number_in,
  input  logic                      stall,
  output logic [N_MEM*MEM_SIZE-1:0] read_add,
  output logic [4:0]                sel,
  output logic                      valid,
  output logic                      send_bx,
  output logic [2:0]                bx_out,
  output logic                      busy,
  output logic                      done,
  output logic                      truncated
);

  localparam int IDX_W = (N_MEM > 1) ? $clog2(N_MEM) : 1;
  localparam logic [4:0] HDR_SEL = 5'h1F;

  typedef enum logic [2:0] {IDLE, HEADER, ARB, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [MEM_SIZE-1:0] remaining [N_MEM];
  logic [MEM_SIZE-1:0] rd_ptr    [N_MEM];
  logic [IDX_W-1:0]    rr_ptr;
  logic [RD_LAT-1:0]   pipe_valid;
  logic [RD_LAT-1:0]   pipe_hdr;
  logic [4:0]          pipe_sel  [RD_LAT];

  logic             any_remaining;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic             grant;
  logic             issue_hdr;
  logic             pipe_pending;
  logic             window_hit;

  always_comb begin
    any_remaining = 1'b0;
    for (int k = 0; k < N_MEM; k++) begin
      if (remaining[k] != '0) any_remaining = 1'b1;
    end
  end

  // First non-empty memory at or after the RR pointer, wrapping past N_MEM-1.
  always_comb begin
    logic [IDX_W:0] probe;
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int i = 0; i < N_MEM; i++) begin
      probe = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (probe >= (IDX_W+1)'(N_MEM)) probe = probe - (IDX_W+1)'(N_MEM);
      if (!grant_found && remaining[probe[IDX_W-1:0]] != '0) begin
        grant_found = 1'b1;
        grant_idx   = probe[IDX_W-1:0];
      end
    end
  end

  // Tokens still inside the pipe after the one currently emerging.
  always_comb begin
    pipe_pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (pipe_valid[i]) pipe_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    issue_hdr  = 1'b0;
    if (start) begin
      state_next = HEADER;
    end else begin
      case (state)
        HEADER: begin
          issue_hdr  = 1'b1;
          state_next = ARB;
        end
        ARB: begin
          grant = !stall && grant_found;
          if ((!stall && !any_remaining) || window_hit) state_next = DRAIN;
        end
        DRAIN: begin
          if (!pipe_pending) state_next = DONE;
        end
        default: state_next = state;
      endcase
    end
  end

  // A start reloads the event and flushes the pipe so no token of the aborted event emerges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_MEM; k++) begin
        remaining[k] <= '0;
        rd_ptr[k]    <= '0;
      end
      rr_ptr     <= '0;
      bx_out     <= '0;
      pipe_valid <= '0;
      pipe_hdr   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_sel[i] <= '0;
    end else if (start) begin
      for (int k = 0; k < N_MEM; k++) begin
        remaining[k] <= number_in[k*MEM_SIZE +: MEM_SIZE];
        rd_ptr[k]    <= '0;
      end
      rr_ptr     <= '0;
      bx_out     <= bx;
      pipe_valid <= '0;
      pipe_hdr   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_sel[i] <= '0;
    end else begin
      if (grant) begin
        remaining[grant_idx] <= remaining[grant_idx] - 1'b1;
        rd_ptr[grant_idx]    <= rd_ptr[grant_idx] + 1'b1;
        rr_ptr               <= (grant_idx == IDX_W'(N_MEM-1)) ? '0 : grant_idx + 1'b1;
      end
      pipe_valid[0] <= grant | issue_hdr;
      pipe_hdr[0]   <= issue_hdr;
      pipe_sel[0]   <= issue_hdr ? HDR_SEL : (grant ? 5'(grant_idx) : 5'd0);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_hdr[i]   <= pipe_hdr[i-1];
        pipe_sel[i]   <= pipe_sel[i-1];
      end
    end
  end

`ifdef READOUT_WINDOW_EN
  localparam int WIN_W = $clog2(WINDOW + 1);
  logic [WIN_W-1:0] win_cnt;
  logic             any_left;

  // Whether any word would remain once this cycle's grant is accounted for.
  always_comb begin
    logic [MEM_SIZE-1:0] left;
    any_left = 1'b0;
    left     = '0;
    for (int k = 0; k < N_MEM; k++) begin
      left = remaining[k];
      if (grant && grant_idx == IDX_W'(k)) left = left - 1'b1;
      if (left != '0) any_left = 1'b1;
    end
  end

  assign window_hit = (state == ARB) && (win_cnt == WIN_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt   <= '0;
      truncated <= 1'b0;
    end else if (start) begin
      win_cnt   <= '0;
      truncated <= 1'b0;
    end else if (state == ARB) begin
      win_cnt <= win_cnt + 1'b1;
      if (window_hit && any_left) truncated <= 1'b1;
    end
  end
`else
  assign window_hit = 1'b0;
  assign truncated  = 1'b0;
`endif

  always_comb begin
    read_add = '0;
    for (int k = 0; k < N_MEM; k++) read_add[k*MEM_SIZE +: MEM_SIZE] = rd_ptr[k];
  end

  assign valid   = pipe_valid[RD_LAT-1] & ~pipe_hdr[RD_LAT-1];
  assign send_bx = pipe_valid[RD_LAT-1] &  pipe_hdr[RD_LAT-1];
  assign sel     = pipe_valid[RD_LAT-1] ? pipe_sel[RD_LAT-1] : 5'd0;
  assign busy    = (state == HEADER) || (state == ARB) || (state == DRAIN);
  assign done    = (state == DONE);

endmodule
